// File: rtl/flash_cmd_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | flash_cmd_sequencer_pkg                                              |
// | State encoding, JEDEC command bytes and status bit positions.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package flash_cmd_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_U1   = 3'd1,
        ST_U2   = 3'd2,
        ST_PROG = 3'd3,
        ST_E1   = 3'd4,
        ST_E2   = 3'd5,
        ST_E3   = 3'd6,
        ST_BUSY = 3'd7
    } state_t;

    localparam logic [7:0] c_CMD_AA = 8'hAA;
    localparam logic [7:0] c_CMD_55 = 8'h55;
    localparam logic [7:0] c_CMD_A0 = 8'hA0;
    localparam logic [7:0] c_CMD_80 = 8'h80;
    localparam logic [7:0] c_CMD_10 = 8'h10;
    localparam logic [7:0] c_CMD_30 = 8'h30;
    localparam logic [7:0] c_CMD_F0 = 8'hF0;

    localparam int c_STAT_BUSY  = 7;
    localparam int c_STAT_ERR   = 6;
    localparam int c_STAT_ERASE = 5;

endpackage
`default_nettype wire

// File: rtl/flash_cmd_sequencer_busy_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | flash_cmd_sequencer_busy_timer                                       |
// | Loadable down-counter that stops at zero and flags it.               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module flash_cmd_sequencer_busy_timer #(
    parameter int TMR_W = 24
) (
    input  logic             m2,
    input  logic             reset_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [TMR_W-1:0] r_count;

    always_ff @(posedge m2 or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/flash_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | flash_cmd_sequencer                                                  |
// | Tracks JEDEC program/erase sequences and gates flash writes.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module flash_cmd_sequencer
    import flash_cmd_sequencer_pkg::*;
#(
    parameter logic [11:0] UNLOCK_ADDR1  = 12'hAAA,
    parameter logic [11:0] UNLOCK_ADDR2  = 12'h555,
    parameter int          PROG_CYCLES   = 24,
    parameter int          SECTOR_CYCLES = 600000,
    parameter int          CHIP_CYCLES   = 16000000,
    parameter int          TMR_W         = 24
) (
    input  logic        m2,
    input  logic        reset_n,
    input  logic        prg_write_enabled,
    input  logic        wr_strobe,
    input  logic [14:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        we_allow,
    output logic        busy,
    output logic [7:0]  status
);

    localparam logic [TMR_W-1:0] c_PROG_LOAD   = TMR_W'(PROG_CYCLES - 1);
    localparam logic [TMR_W-1:0] c_SECTOR_LOAD = TMR_W'(SECTOR_CYCLES - 1);
    localparam logic [TMR_W-1:0] c_CHIP_LOAD   = TMR_W'(CHIP_CYCLES - 1);

    state_t           r_state;
    logic             r_err;
    logic             r_erase_op;
    logic             r_busy;
    logic             r_we_allow;

    logic             w_wr;
    logic             w_a1;
    logic             w_a2;
    logic             w_is_f0;
    logic             w_load;
    logic [TMR_W-1:0] w_load_val;
    logic             w_tmr_zero;
    logic             w_unused;

    assign w_wr     = wr_strobe & prg_write_enabled & (r_state != ST_BUSY);
    assign w_a1     = (wr_addr[11:0] == UNLOCK_ADDR1);
    assign w_a2     = (wr_addr[11:0] == UNLOCK_ADDR2);
    assign w_is_f0  = (wr_data == c_CMD_F0);
    assign w_unused = &{1'b0, wr_addr[14:12]};

    // F0 is a reset in every non-busy state, so it never starts a timer.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        if (w_wr && !w_is_f0) begin
            case (r_state)
                ST_PROG: begin
                    w_load     = 1'b1;
                    w_load_val = c_PROG_LOAD;
                end
                ST_E3: begin
                    if ((wr_data == c_CMD_10) && w_a1) begin
                        w_load     = 1'b1;
                        w_load_val = c_CHIP_LOAD;
                    end else if (wr_data == c_CMD_30) begin
                        w_load     = 1'b1;
                        w_load_val = c_SECTOR_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    flash_cmd_sequencer_busy_timer #(
        .TMR_W (TMR_W)
    ) u_busy_timer (
        .m2       (m2),
        .reset_n  (reset_n),
        .load     (w_load),
        .load_val (w_load_val),
        .dec      (r_state == ST_BUSY),
        .zero     (w_tmr_zero)
    );

    always_ff @(posedge m2 or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_err      <= 1'b0;
            r_erase_op <= 1'b0;
            r_busy     <= 1'b0;
            r_we_allow <= 1'b0;
        end else begin
            r_we_allow <= prg_write_enabled & ~r_busy;
            if (r_state == ST_BUSY) begin
                if (wr_strobe) begin
                    r_err <= 1'b1;
                end
                if (w_tmr_zero) begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_erase_op <= 1'b0;
                end
            end else if (w_wr) begin
                if (w_is_f0) begin
                    r_state <= ST_IDLE;
                    if (r_state == ST_IDLE) begin
                        r_err <= 1'b0;
                    end
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            if ((wr_data == c_CMD_AA) && w_a1) begin
                                r_state <= ST_U1;
                            end
                        end
                        ST_U1: begin
                            if ((wr_data == c_CMD_55) && w_a2) begin
                                r_state <= ST_U2;
                            end else begin
                                r_state <= ST_IDLE;
                                r_err   <= 1'b1;
                            end
                        end
                        ST_U2: begin
                            if ((wr_data == c_CMD_A0) && w_a1) begin
                                r_state <= ST_PROG;
                            end else if ((wr_data == c_CMD_80) && w_a1) begin
                                r_state <= ST_E1;
                            end else begin
                                r_state <= ST_IDLE;
                                r_err   <= 1'b1;
                            end
                        end
                        ST_PROG: begin
                            r_state    <= ST_BUSY;
                            r_busy     <= 1'b1;
                            r_erase_op <= 1'b0;
                        end
                        ST_E1: begin
                            if ((wr_data == c_CMD_AA) && w_a1) begin
                                r_state <= ST_E2;
                            end else begin
                                r_state <= ST_IDLE;
                                r_err   <= 1'b1;
                            end
                        end
                        ST_E2: begin
                            if ((wr_data == c_CMD_55) && w_a2) begin
                                r_state <= ST_E3;
                            end else begin
                                r_state <= ST_IDLE;
                                r_err   <= 1'b1;
                            end
                        end
                        ST_E3: begin
                            if (w_load) begin
                                r_state    <= ST_BUSY;
                                r_busy     <= 1'b1;
                                r_erase_op <= 1'b1;
                            end else begin
                                r_state <= ST_IDLE;
                                r_err   <= 1'b1;
                            end
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign we_allow = r_we_allow;
    assign busy     = r_busy;
    assign status   = {r_busy, r_err, r_erase_op, 2'b00, r_state};

endmodule
`default_nettype wire

// File: tb/tb_flash_cmd_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_flash_cmd_sequencer                                               |
// | Directed scoreboard bench; erase times shortened to keep runs quick. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_flash_cmd_sequencer;

    localparam int c_PROG   = 24;
    localparam int c_SECTOR = 600;
    localparam int c_CHIP   = 3000;

    logic        m2;
    logic        reset_n;
    logic        prg_write_enabled;
    logic        wr_strobe;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic        we_allow;
    logic        busy;
    logic [7:0]  status;

    typedef struct {
        string      name;
        logic [7:0] st;
        logic       we;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    flash_cmd_sequencer #(
        .UNLOCK_ADDR1  (12'hAAA),
        .UNLOCK_ADDR2  (12'h555),
        .PROG_CYCLES   (c_PROG),
        .SECTOR_CYCLES (c_SECTOR),
        .CHIP_CYCLES   (c_CHIP),
        .TMR_W         (24)
    ) dut (
        .m2                (m2),
        .reset_n           (reset_n),
        .prg_write_enabled (prg_write_enabled),
        .wr_strobe         (wr_strobe),
        .wr_addr           (wr_addr),
        .wr_data           (wr_data),
        .we_allow          (we_allow),
        .busy              (busy),
        .status            (status)
    );

    initial m2 = 1'b0;
    always #5 m2 = ~m2;

    // Monitor: outputs are settled mid-cycle, so sample on the falling edge.
    always @(negedge m2) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_cmp++;
            if (status !== e.st || we_allow !== e.we || busy !== e.st[7]) begin
                n_fail++;
                $display("FAIL %s: status=%h we_allow=%b busy=%b, required status=%h we_allow=%b busy=%b",
                         e.name, status, we_allow, busy, e.st, e.we, e.st[7]);
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] st, input logic we);
        exp_t e;
        e.name = name;
        e.st   = st;
        e.we   = we;
        sb_q.push_back(e);
    endtask

    task automatic wr(input logic [14:0] a, input logic [7:0] d);
        wr_addr   = a;
        wr_data   = d;
        wr_strobe = 1'b1;
        @(posedge m2);
        #1;
        wr_strobe = 1'b0;
    endtask

    task automatic tick;
        @(posedge m2);
        #1;
    endtask

    initial begin
        reset_n           = 1'b0;
        prg_write_enabled = 1'b1;
        wr_strobe         = 1'b0;
        wr_addr           = '0;
        wr_data           = '0;
        repeat (2) @(posedge m2);
        #1;
        chk("reset", 8'h00, 1'b0);
        tick();
        reset_n = 1'b1;
        chk("reset_release", 8'h00, 1'b0);
        tick();
        chk("idle_we", 8'h00, 1'b1);

        // Program sequence with exact busy length
        wr(15'h0AAA, 8'hAA); chk("prog_u1", 8'h01, 1'b1);
        wr(15'h0555, 8'h55); chk("prog_u2", 8'h02, 1'b1);
        wr(15'h0AAA, 8'hA0); chk("prog_prog", 8'h03, 1'b1);
        wr(15'h1234, 8'h3C); chk("prog_busy0", 8'h87, 1'b1);
        for (int i = 1; i < c_PROG; i++) begin
            tick(); chk("prog_busy", 8'h87, 1'b0);
        end
        tick(); chk("prog_done", 8'h00, 1'b0);
        tick(); chk("prog_we_back", 8'h00, 1'b1);

        // Sector erase
        wr(15'h0AAA, 8'hAA); chk("sec_u1", 8'h01, 1'b1);
        wr(15'h0555, 8'h55); chk("sec_u2", 8'h02, 1'b1);
        wr(15'h0AAA, 8'h80); chk("sec_e1", 8'h04, 1'b1);
        wr(15'h0AAA, 8'hAA); chk("sec_e2", 8'h05, 1'b1);
        wr(15'h0555, 8'h55); chk("sec_e3", 8'h06, 1'b1);
        wr(15'h2000, 8'h30); chk("sec_busy0", 8'hA7, 1'b1);
        for (int i = 1; i < c_SECTOR; i++) begin
            tick(); chk("sec_busy", 8'hA7, 1'b0);
        end
        tick(); chk("sec_done", 8'h00, 1'b0);
        tick(); chk("sec_we_back", 8'h00, 1'b1);

        // Bad sequence, sticky err, F0 clear
        wr(15'h0AAA, 8'hAA); chk("bad_u1", 8'h01, 1'b1);
        wr(15'h0555, 8'h12); chk("bad_err", 8'h40, 1'b1);
        wr(15'h0AAA, 8'hAA); chk("err_sticky", 8'h41, 1'b1);
        wr(15'h0123, 8'hF0); chk("f0_to_idle", 8'h40, 1'b1);
        wr(15'h0123, 8'hF0); chk("f0_clear", 8'h00, 1'b1);

        // Write while busy: err set, timer unaffected
        wr(15'h0AAA, 8'hAA);
        wr(15'h0555, 8'h55);
        wr(15'h0AAA, 8'hA0);
        wr(15'h7FFF, 8'h99); chk("wb_busy0", 8'h87, 1'b1);
        for (int i = 1; i < c_PROG; i++) begin
            if (i == 5) begin
                wr_addr   = 15'h0000;
                wr_data   = 8'h77;
                wr_strobe = 1'b1;
            end
            tick();
            wr_strobe = 1'b0;
            chk("wb_busy", (i >= 5) ? 8'hC7 : 8'h87, 1'b0);
        end
        tick(); chk("wb_done", 8'h40, 1'b0);
        tick(); chk("wb_we_back", 8'h40, 1'b1);
        wr(15'h0000, 8'hF0); chk("wb_clear", 8'h00, 1'b1);

        // Flash writes disabled
        prg_write_enabled = 1'b0;
        wr(15'h0AAA, 8'hAA); chk("dis_aa", 8'h00, 1'b0);
        wr(15'h0555, 8'h55); chk("dis_55", 8'h00, 1'b0);
        wr(15'h0AAA, 8'hA0); chk("dis_a0", 8'h00, 1'b0);
        wr(15'h1234, 8'h3C); chk("dis_data", 8'h00, 1'b0);
        prg_write_enabled = 1'b1;
        tick(); chk("dis_we_back", 8'h00, 1'b1);
        wr(15'h0AAA, 8'hAA); chk("hold_u1", 8'h01, 1'b1);
        prg_write_enabled = 1'b0;
        wr(15'h0555, 8'h55); chk("hold_state", 8'h01, 1'b0);
        prg_write_enabled = 1'b1;
        wr(15'h0555, 8'h55); chk("hold_resume", 8'h02, 1'b1);
        wr(15'h0000, 8'hF0); chk("hold_f0", 8'h00, 1'b1);

        // Chip erase aborted by reset when the timer reads 1000
        wr(15'h0AAA, 8'hAA);
        wr(15'h0555, 8'h55);
        wr(15'h0AAA, 8'h80);
        wr(15'h0AAA, 8'hAA);
        wr(15'h0555, 8'h55);
        wr(15'h0AAA, 8'h10); chk("chip_busy0", 8'hA7, 1'b1);
        repeat (c_CHIP - 1 - 1000 - 1) tick();
        chk("chip_busy", 8'hA7, 1'b0);
        tick();
        reset_n = 1'b0;
        chk("chip_async_rst", 8'h00, 1'b0);
        tick();
        reset_n = 1'b1;
        chk("chip_rst_release", 8'h00, 1'b0);
        tick(); chk("chip_we_back", 8'h00, 1'b1);

        repeat (3) tick();
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
